// File: rtl/muldiv_hilo_ctrl.sv
// HI/LO issue and writeback controller for the sequential Booth multiplier.
// Optional MADD/MSUB accumulate path is enabled by defining MULT_ACC_EN.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | accepting ops; MTxx/MFxx complete in place
//   S_START | one-cycle start pulse to the multiplier, operands held
//   S_WAIT  | minimum latency elapsed and busy dropped -> commit HI/LO
module muldiv_hilo_ctrl #(
  parameter int DATA_W      = 32,
  parameter int MUL_LATENCY = 34,
  parameter int CNT_W       = 6
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                op_valid_i,
  input  logic [2:0]          op_code_i,
  input  logic [DATA_W-1:0]   rs_val_i,
  input  logic [DATA_W-1:0]   rt_val_i,
  output logic                op_ready_o,
  output logic [DATA_W-1:0]   rd_data_o,
  output logic                rd_valid_o,
  output logic                mul_done_o,
  output logic                mul_start_o,
  output logic [DATA_W-1:0]   mul_mc_o,
  output logic [DATA_W-1:0]   mul_mp_o,
  input  logic [2*DATA_W-1:0] mul_prod_i,
  input  logic                mul_busy_i,
  output logic [DATA_W-1:0]   hi_o,
  output logic [DATA_W-1:0]   lo_o
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MTHI  = 3'b010;
  localparam logic [2:0] OP_MTLO  = 3'b011;
  localparam logic [2:0] OP_MFHI  = 3'b100;
  localparam logic [2:0] OP_MFLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;

  localparam logic [CNT_W-1:0] CNT_EXIT = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   mc_q, mc_d;
  logic [DATA_W-1:0]   mp_q, mp_d;
  logic                uns_q, uns_d;

  logic [DATA_W-1:0]   prod_hi_fix;
  logic [2*DATA_W-1:0] prod_fix;
  logic [2*DATA_W-1:0] commit_val;

  // The multiplier is signed-only; MULTU adds back the operands whose MSB
  // was misread as a sign bit.
  always_comb begin
    prod_hi_fix = mul_prod_i[2*DATA_W-1:DATA_W];
    if (uns_q) begin
      if (mc_q[DATA_W-1]) prod_hi_fix = prod_hi_fix + mp_q;
      if (mp_q[DATA_W-1]) prod_hi_fix = prod_hi_fix + mc_q;
    end
  end

  assign prod_fix = {prod_hi_fix, mul_prod_i[DATA_W-1:0]};

`ifdef MULT_ACC_EN
  logic                acc_q, acc_d;
  logic                sub_q, sub_d;
  logic [2*DATA_W-1:0] acc_sum;

  assign acc_sum    = sub_q ? ({hi_q, lo_q} - prod_fix) : ({hi_q, lo_q} + prod_fix);
  assign commit_val = acc_q ? acc_sum : prod_fix;
`else
  assign commit_val = prod_fix;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    mc_d       = mc_q;
    mp_d       = mp_q;
    uns_d      = uns_q;
`ifdef MULT_ACC_EN
    acc_d      = acc_q;
    sub_d      = sub_q;
`endif
    op_ready_o  = (state_q == S_IDLE);
    mul_start_o = (state_q == S_START);

    case (state_q)
      S_IDLE: begin
        if (op_valid_i) begin
          case (op_code_i)
            OP_MULT, OP_MULTU: begin
              mc_d    = rs_val_i;
              mp_d    = rt_val_i;
              uns_d   = (op_code_i == OP_MULTU);
`ifdef MULT_ACC_EN
              acc_d   = 1'b0;
              sub_d   = 1'b0;
`endif
              state_d = S_START;
            end
            OP_MTHI: hi_d = rs_val_i;
            OP_MTLO: lo_d = rs_val_i;
            OP_MFHI: begin
              rd_data_d  = hi_q;
              rd_valid_d = 1'b1;
            end
            OP_MFLO: begin
              rd_data_d  = lo_q;
              rd_valid_d = 1'b1;
            end
            OP_MADD, OP_MSUB: begin
`ifdef MULT_ACC_EN
              mc_d    = rs_val_i;
              mp_d    = rt_val_i;
              uns_d   = 1'b0;
              acc_d   = 1'b1;
              sub_d   = (op_code_i == OP_MSUB);
              state_d = S_START;
`endif
            end
            default: ;
          endcase
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        if ((cnt_q >= CNT_EXIT) && !mul_busy_i) begin
          hi_d    = commit_val[2*DATA_W-1:DATA_W];
          lo_d    = commit_val[DATA_W-1:0];
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      mc_q       <= '0;
      mp_q       <= '0;
      uns_q      <= 1'b0;
`ifdef MULT_ACC_EN
      acc_q      <= 1'b0;
      sub_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      mc_q       <= mc_d;
      mp_q       <= mp_d;
      uns_q      <= uns_d;
`ifdef MULT_ACC_EN
      acc_q      <= acc_d;
      sub_q      <= sub_d;
`endif
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign mul_done_o = done_q;
  assign mul_mc_o   = mc_q;
  assign mul_mp_o   = mp_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: doc/muldiv_hilo_ctrl.md
Name: muldiv_hilo_ctrl

Overview:
- Issue/writeback controller sitting directly downstream of the signed sequential Booth multiplier in the EX stage.
- Accepts MULT/MULTU/MTHI/MTLO/MFHI/MFLO from the pipeline and launches the multiplier with a one-cycle start pulse.
- Waits out the multiplier's busy window, corrects the signed product for MULTU, and commits it to architectural HI/LO.
- Backpressures the pipeline (op_ready low) while a multiply is in flight.

Parameters:
- DATA_W, 32, operand and HI/LO width.
- MUL_LATENCY, 34, minimum cycles held in WAIT after the start pulse before the product is sampled.
- CNT_W, 6, width of the internal wait counter; must satisfy 2^CNT_W > MUL_LATENCY.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- op_valid  in  1  pipeline presents an op.
- op_code  in  3  000 MULT, 001 MULTU, 010 MTHI, 011 MTLO, 100 MFHI, 101 MFLO, 110 MADD, 111 MSUB.
- rs_val  in  DATA_W  operand A / MTHI-MTLO source.
- rt_val  in  DATA_W  operand B.
- op_ready  out  1  op accepted when op_valid & op_ready.
- rd_data  out  DATA_W  MFHI/MFLO result.
- rd_valid  out  1  one-cycle pulse qualifying rd_data.
- mul_done  out  1  one-cycle pulse, cycle after HI/LO commit of a multiply.
- mul_start  out  1  to multiplier start.
- mul_mc  out  DATA_W  to multiplier multiplicand.
- mul_mp  out  DATA_W  to multiplier multiplier.
- mul_prod  in  2*DATA_W  from multiplier product.
- mul_busy  in  1  from multiplier busy.
- hi  out  DATA_W  architectural HI.
- lo  out  DATA_W  architectural LO.

Behaviour:
- Reset: state=IDLE; hi=lo=0; rd_data=0; rd_valid=0; mul_done=0; mul_start=0; mul_mc=mul_mp=0; counter=0. op_ready=1 in IDLE.
- A reset mid-multiply abandons the operation; HI/LO stay 0 and no mul_done fires.
- FSM states: IDLE, START, WAIT.
- IDLE: op_ready=1. On accept:
  - MULT/MULTU/(MADD/MSUB): latch rs->mul_mc, rt->mul_mp, latch unsigned flag and op kind; go to START.
  - MTHI/MTLO: write hi/lo at that edge; stay IDLE.
  - MFHI/MFLO: rd_data<=hi/lo at that edge, rd_valid=1 next cycle; stay IDLE. Back-to-back accepts give back-to-back rd_valid.
- START (1 cycle): mul_start=1, op_ready=0, operands stable; counter<=0; go to WAIT.
- WAIT: op_ready=0, mul_start=0, counter increments each cycle. Exit when counter>=MUL_LATENCY-1 and mul_busy==0. At the exit edge hi/lo<={corrected product}; mul_done=1 the following cycle; go to IDLE.
- MULT: {hi,lo}=mul_prod.
- MULTU: lo=mul_prod[31:0]; hi=mul_prod[63:32] + (mc[31]?mp:0) + (mp[31]?mc:0), mod 2^32.
- The counter saturates and never wraps.
- op_ready is combinational from state only; inputs are ignored while op_ready=0.
- Without MULT_ACC_EN, op_codes 110/111 are accepted in one cycle with no effect on any output.

Optional Feature:
- Macro: MULT_ACC_EN.
- Defined: 110 MADD and 111 MSUB run the signed multiply path, then {hi,lo}<={hi,lo} ± mul_prod as a 64-bit add/sub, wrapping mod 2^64, committed at the WAIT exit edge.
- Undefined: 110/111 are no-ops as stated above; no 64-bit adder is instantiated.

Test Plan:
- Reset with rst_n low mid-WAIT -> hi=lo=0, op_ready=1 immediately, mul_start=0, no mul_done.
- MULT rs=7, rt=0xFFFFFFFD -> one mul_start pulse; op_ready low MUL_LATENCY+1 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFEB; mul_done pulse.
- MULTU rs=0xFFFFFFFF, rt=2 -> hi=0x00000001, lo=0xFFFFFFFE.
- MTHI 0x12345678, then MFHI on next cycle -> rd_valid pulse with rd_data=0x12345678; MFLO held during a multiply is stalled until IDLE and then returns the new lo.
- Multiplier model holding mul_busy high 5 cycles past MUL_LATENCY -> WAIT extends exactly 5 cycles; counter does not wrap.
- MULT_ACC_EN defined: {hi,lo}=0x0_00000010, MADD 3*4 -> lo=0x1C; then MSUB 0xFFFFFFFF*1 -> lo=0x1D. Undefined: same ops leave hi/lo unchanged with op_ready high.
